serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial two's-complement subtractor computing D = A − B − Bin one bit per clock, LSB first, with a single borrow flip-flop. It is the inverse-operation, sequential counterpart of the team's combinational ripple-carry adder, trading area for latency. It sits behind a start/done handshake so a board wrapper or a controlling FSM can drive it.

## Interface

- WIDTH, 4, operand and result width in bits (≥ 2)
- clock  input  1  rising-edge clock; the only clock
- resetn  input  1  synchronous active-low reset, sampled on the rising edge of clock
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  minuend, captured when start is accepted
- b  input  WIDTH  subtrahend, captured when start is accepted
- bin  input  1  borrow-in, captured when start is accepted
- busy  output  1  high while an operation is in progress (SHIFT)
- done  output  1  one-cycle pulse; diff/bout valid in that cycle
- diff  output  WIDTH  result A − B − Bin mod 2^WIDTH
- bout  output  1  borrow-out; 1 iff A < B + Bin as unsigned values

## Operation

- States: IDLE, SHIFT, DONE.
- Reset (resetn=0 at an edge): state←IDLE. busy, done, diff, and bout←0. The internal shift registers, borrow, and count←0. Reset overrides every other condition, including an operation in flight.
- IDLE: if start=1, capture ra←a, rb←b, borrow←bin, count←0, and go to SHIFT. Otherwise hold.
- SHIFT, each edge:
  - d = ra[0]^rb[0]^borrow.
  - borrow←(~ra[0]&rb[0]) | (~ra[0]&borrow) | (rb[0]&borrow).
  - ra, rb shift right by 1.
  - The result register shifts right with d entering the MSB.
  - count←count+1.
  - On the edge where count==WIDTH−1, go to DONE. On that edge, load diff with the completed result register and bout with the final borrow.
- DONE: done=1 for exactly this cycle. Next edge: if start=1, behave as IDLE accepting start (capture, go to SHIFT). Otherwise go to IDLE.
- start in SHIFT is ignored. It is not queued.
- diff and bout hold their value from the last completion until the next completion or reset. They do not change during SHIFT.
- Inputs a, b, and bin may change freely after capture.
- count width is clog2(WIDTH)+1. It never wraps within an operation.

## Timing

- Start accepted at edge E0. busy=1 from E0 through the cycle before edge E0+WIDTH.
- diff, bout, and done are updated at edge E0+WIDTH. done is high for the single cycle following that edge.
- Latency from start acceptance to done is WIDTH cycles.
- Back-to-back throughput: one result per WIDTH+1 cycles, with start held or re-asserted during DONE.
- busy and done are never high simultaneously. Both are registered outputs, not combinational from inputs.
- Reset asserted during SHIFT aborts the operation. busy=0 and done=0 from the next cycle, with no done pulse. diff/bout read 0.

## Structure

- A shared package / header holds the state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant.
- Sub-module full_subtractor_cell is a combinational 1-bit cell with inputs x, y, bi and outputs d, bo. It is instantiated once and drives the shift datapath.
- A board wrapper is out of scope for this block.

## Test plan

- WIDTH=4, a=9, b=3, bin=0, start pulse → done exactly 4 cycles after acceptance; diff=6, bout=0.
- a=3, b=9, bin=0 → diff=4'hA, bout=1. Then a=0, b=0, bin=1 → diff=4'hF, bout=1.
- a=15, b=15, bin=0 → diff=0, bout=0. Then a=15, b=0, bin=1 → diff=14, bout=0. Exhaustive sweep of all 512 (a, b, bin) combinations matches the golden (a−b−bin) mod 16 and borrow.
- Start re-pulsed with different operands mid-SHIFT → ignored; the original result is delivered; busy is unaffected.
- Start held high continuously with a=7, b=2 → done every 5 cycles, diff=5 each time; busy low only in DONE cycles.
- resetn=0 for one edge at the second SHIFT cycle → busy=0, done never pulses, diff=0, bout=0; a subsequent start completes normally.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor: FSM state encodings
//   and the default operand width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell
//   Combinational 1-bit full subtractor: d = x - y - bi, with borrow-out.
//   Ports:
//     x  - minuend bit
//     y  - subtrahend bit
//     bi - borrow in
//     d  - difference bit
//     bo - borrow out
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor, D = A - B - Bin, LSB first,
//   one bit per clock, behind a start/done handshake.
//   Ports:
//     clock  - rising-edge clock
//     resetn - synchronous active-low reset
//     start  - request, sampled in IDLE or DONE
//     a, b   - minuend / subtrahend, captured on accepted start
//     bin    - borrow in, captured on accepted start
//     busy   - operation in progress
//     done   - one-cycle pulse, diff/bout valid
//     diff   - A - B - Bin mod 2^WIDTH (held until next completion)
//     bout   - 1 iff A < B + Bin unsigned (held until next completion)
//
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | one result bit produced per edge, WIDTH edges total
//   DONE  | result just loaded, done pulse; start may be accepted again
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             finish;

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-2:0] res;
  logic             borrow;
  logic [CW-1:0]    count;

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] res_full;

  full_subtractor_cell u_cell (
    .x  (ra[0]),
    .y  (rb[0]),
    .bi (borrow),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // Partial result with the new bit on top; on the final edge this is the
  // complete difference, otherwise its upper WIDTH-1 bits are kept.
  assign res_full = {cell_d, res};

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = SHIFT;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (count == LAST) begin
          state_next = DONE;
          finish     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ra     <= '0;
      rb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      count  <= '0;
    end else begin
      // Flags registered from the next state so they track state exactly.
      busy <= (state_next == SHIFT);
      done <= (state_next == DONE);
      if (accept) begin
        ra     <= a;
        rb     <= b;
        borrow <= bin;
        count  <= '0;
      end else if (state == SHIFT) begin
        ra     <= ra >> 1;
        rb     <= rb >> 1;
        borrow <= cell_bo;
        res    <= res_full[WIDTH-1:1];
        count  <= count + 1'b1;
        if (finish) begin
          diff <= res_full;
          bout <= cell_bo;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clock;
  logic             resetn;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .bout   (bout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one operation and check latency and result. Entered and left at
  // 1 unit after a rising edge; leaves in the DONE cycle.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tbin, input logic [WIDTH-1:0] ediff,
                        input logic ebout, input string tag);
    int cyc;
    a = ta; b = tb; bin = tbin; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, WIDTH);
    check({tag, "_diff"}, diff, ediff);
    check({tag, "_bout"}, bout, ebout);
  endtask

  initial begin
    logic [WIDTH:0] gold;
    int cyc;
    int last_done;
    int ndone;
    logic seen_done;

    resetn = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    resetn = 1'b1;
    tick();

    run_op(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, "9m3");
    tick();
    run_op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, "3m9");
    run_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, "0m0b");
    run_op(4'd15, 4'd15, 1'b0, 4'd0, 1'b0, "fmf");
    run_op(4'd15, 4'd0, 1'b1, 4'd14, 1'b0, "fm0b");
    tick();

    // Exhaustive sweep against an independent 5-bit arithmetic model.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          gold = {1'b0, 4'(ia)} - {1'b0, 4'(ib)} - 5'(ic);
          run_op(4'(ia), 4'(ib), 1'(ic), gold[3:0], gold[4], "sweep");
        end
      end
    end
    tick();

    // Re-pulse start mid-SHIFT: ignored, result and busy unaffected.
    run_op(4'd1, 4'd1, 1'b0, 4'd0, 1'b0, "pre_ign");
    tick();
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'd2; b = 4'd8; bin = 1'b1; start = 1'b1;
    check("ign_busy_before", busy, 1);
    check("ign_diff_hold", diff, 0);
    tick();
    start = 1'b0;
    check("ign_busy_after", busy, 1);
    cyc = 2;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    check("ign_latency", cyc, WIDTH);
    check("ign_diff", diff, 6);
    check("ign_bout", bout, 0);
    tick();

    // Start held high: one result every WIDTH+1 cycles.
    a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
    tick();
    last_done = -1;
    ndone = 0;
    for (int c = 1; c <= 16; c++) begin
      check("held_busy_xor_done", busy, !done);
      if (done) begin
        check("held_diff", diff, 5);
        if (last_done >= 0) check("held_period", c - last_done, WIDTH + 1);
        last_done = c;
        ndone++;
      end
      tick();
    end
    check("held_count", ndone, 3);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    check("held_idle", busy, 0);

    // Reset during the second SHIFT cycle aborts the operation.
    check("pre_rst_diff", diff, 5);
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    seen_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    check("abort_no_done", seen_done, 0);
    check("abort_busy_later", busy, 0);
    run_op(4'd7, 4'd2, 1'b0, 4'd5, 1'b0, "post_rst");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
